// File: rtl/seq_tracker_fsm.sv
// rtl/seq_tracker_fsm.sv - parametrised symbol-sequence tracking FSM with selectable state encoding
module seq_tracker_fsm #(
    parameter int NUM_STATES    = 32,
    parameter int SYM_W         = 2,
    parameter int ENCODING      = 0,
    parameter int MISMATCH_MODE = 0,
    parameter int TIMEOUT       = 0,
    localparam int IDX_W        = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1,
    localparam int STATE_W      = (ENCODING == 0) ? NUM_STATES : IDX_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [SYM_W-1:0]   in,
    output logic [STATE_W-1:0] state,
    output logic [IDX_W-1:0]   state_idx,
    output logic               out_signal,
    output logic               wrap,
    output logic [15:0]        wrap_count,
    output logic               illegal,
    output logic               timeout_evt
);

    localparam int ENC_ONEHOT = 0;
    localparam int ENC_GRAY   = 2;

    logic [STATE_W-1:0] r_state;
    logic               r_wrap;
    logic [15:0]        r_wrap_count;
    logic               r_illegal;
    logic               r_timeout_evt;
    logic [15:0]        r_idle;

    logic [IDX_W-1:0]   w_dec;
    logic               w_legal;
    logic [IDX_W-1:0]   w_nxt_idx;
    logic [SYM_W-1:0]   w_exp_sym;
    logic               w_last;
    logic               w_in_s0;
    logic               w_adv;
    logic               w_restart;
    logic               w_timeout;

    // Maps a state index onto the configured register encoding.
    function automatic logic [STATE_W-1:0] f_encode(input logic [IDX_W-1:0] idx);
        logic [STATE_W-1:0] v;
        if (ENCODING == ENC_ONEHOT) begin
            v = STATE_W'(1) << idx;
        end else if (ENCODING == ENC_GRAY) begin
            v = STATE_W'(idx ^ (idx >> 1));
        end else begin
            v = STATE_W'(idx);
        end
        return v;
    endfunction

    // Decode the state register to an index and flag encodings that are not a real state.
    always_comb begin
        w_dec   = '0;
        w_legal = 1'b0;
        if (ENCODING == ENC_ONEHOT) begin
            for (int k = 0; k < STATE_W; k++) begin
                if (r_state[k]) begin
                    w_dec = w_dec | IDX_W'(k);
                end
            end
            w_legal = $onehot(r_state);
        end else if (ENCODING == ENC_GRAY) begin
            w_dec[IDX_W-1] = r_state[IDX_W-1];
            for (int k = IDX_W - 2; k >= 0; k--) begin
                w_dec[k] = w_dec[k+1] ^ r_state[k];
            end
            w_legal = (32'(w_dec) < 32'(NUM_STATES));
        end else begin
            w_dec   = r_state[IDX_W-1:0];
            w_legal = (32'(w_dec) < 32'(NUM_STATES));
        end
    end

    // Transition conditions; an illegal state suppresses everything except recovery.
    always_comb begin
        w_exp_sym = SYM_W'(w_dec);
        w_last    = (w_dec == IDX_W'(NUM_STATES - 1));
        w_nxt_idx = w_last ? '0 : (w_dec + IDX_W'(1));
        w_in_s0   = w_legal && (w_dec == '0);
        w_adv     = w_legal && in_valid && (in == w_exp_sym);
        w_restart = (MISMATCH_MODE != 0) && in_valid && !w_adv;
        w_timeout = (TIMEOUT != 0) && !w_in_s0 && !w_adv &&
                    (r_idle == 16'(TIMEOUT - 1));
    end

    // State register, pulse flags, wrap counter and idle counter in priority order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= f_encode('0);
            r_wrap        <= 1'b0;
            r_wrap_count  <= 16'd0;
            r_illegal     <= 1'b0;
            r_timeout_evt <= 1'b0;
            r_idle        <= 16'd0;
        end else begin
            r_wrap        <= 1'b0;
            r_timeout_evt <= 1'b0;
            if (!w_legal) begin
                r_state   <= f_encode('0);
                r_illegal <= 1'b1;
                r_idle    <= 16'd0;
            end else if (w_adv) begin
                r_state <= f_encode(w_nxt_idx);
                r_idle  <= 16'd0;
                if (w_last) begin
                    r_wrap       <= 1'b1;
                    r_wrap_count <= r_wrap_count + 16'd1;
                end
            end else if (w_restart) begin
                r_state <= f_encode('0);
                r_idle  <= 16'd0;
            end else if (w_timeout) begin
                r_state       <= f_encode('0);
                r_idle        <= 16'd0;
                r_timeout_evt <= 1'b1;
            end else if ((TIMEOUT != 0) && !w_in_s0) begin
                r_idle <= r_idle + 16'd1;
            end else begin
                r_idle <= 16'd0;
            end
        end
    end

    assign state       = r_state;
    assign state_idx   = w_legal ? w_dec : '0;
    assign out_signal  = ^r_state;
    assign wrap        = r_wrap;
    assign wrap_count  = r_wrap_count;
    assign illegal     = r_illegal;
    assign timeout_evt = r_timeout_evt;

endmodule

// File: tb/tb_seq_tracker_fsm.sv
// tb/tb_seq_tracker_fsm.sv - directed-vector bench for seq_tracker_fsm across encodings and modes
module tb_seq_tracker_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       a_valid = 1'b0;
    logic [1:0] a_in    = 2'd0;
    logic       b_valid = 1'b0;
    logic [1:0] b_in    = 2'd0;

    logic [31:0] d_state;  logic [4:0] d_idx;  logic d_out, d_wrap, d_ill, d_tev;  logic [15:0] d_wc;
    logic [31:0] m_state;  logic [4:0] m_idx;  logic m_out, m_wrap, m_ill, m_tev;  logic [15:0] m_wc;
    logic [3:0]  g_state;  logic [3:0] g_idx;  logic g_out, g_wrap, g_ill, g_tev;  logic [15:0] g_wc;
    logic [3:0]  n_state;  logic [3:0] n_idx;  logic n_out, n_wrap, n_ill, n_tev;  logic [15:0] n_wc;

    seq_tracker_fsm u_def (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in(a_in),
        .state(d_state), .state_idx(d_idx), .out_signal(d_out), .wrap(d_wrap),
        .wrap_count(d_wc), .illegal(d_ill), .timeout_evt(d_tev)
    );

    seq_tracker_fsm #(.MISMATCH_MODE(1)) u_mm (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in(a_in),
        .state(m_state), .state_idx(m_idx), .out_signal(m_out), .wrap(m_wrap),
        .wrap_count(m_wc), .illegal(m_ill), .timeout_evt(m_tev)
    );

    seq_tracker_fsm #(.NUM_STATES(12), .ENCODING(2), .TIMEOUT(4)) u_gray (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in(b_in),
        .state(g_state), .state_idx(g_idx), .out_signal(g_out), .wrap(g_wrap),
        .wrap_count(g_wc), .illegal(g_ill), .timeout_evt(g_tev)
    );

    seq_tracker_fsm #(.NUM_STATES(12), .ENCODING(1)) u_bin (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in(b_in),
        .state(n_state), .state_idx(n_idx), .out_signal(n_out), .wrap(n_wrap),
        .wrap_count(n_wc), .illegal(n_ill), .timeout_evt(n_tev)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] gray_code [12] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7,
                                   4'd5, 4'd4, 4'd12, 4'd13, 4'd15, 4'd14};
    logic       gray_par  [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) step();
        check_val("rst_def_state", d_state, 32'h1);
        check_val("rst_def_idx", d_idx, 0);
        check_val("rst_def_out", d_out, 1);
        check_val("rst_def_wrap", d_wrap, 0);
        check_val("rst_def_wc", d_wc, 0);
        check_val("rst_def_ill", d_ill, 0);
        check_val("rst_def_tev", d_tev, 0);
        check_val("rst_gray_state", g_state, 0);
        check_val("rst_gray_out", g_out, 0);
        #2 reset = 1'b0;

        // Full 32-state walk on the default one-hot tracker.
        a_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a_in = 2'(i % 4);
            step();
            check_val($sformatf("walk_idx%0d", i), d_idx, (i + 1) % 32);
            check_val($sformatf("walk_out%0d", i), d_out, 1);
            check_val($sformatf("walk_wrap%0d", i), d_wrap, (i == 31) ? 1 : 0);
        end
        a_valid = 1'b0;
        step();
        check_val("walk_wrap_end", d_wrap, 0);
        check_val("walk_wc", d_wc, 1);

        // Mismatch: hold in mode 0, restart in mode 1.
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_in = 2'(i % 4);
            step();
        end
        check_val("mm_def_s5", d_idx, 5);
        check_val("mm_mm_s5", m_idx, 5);
        a_in = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("mm_def_hold%0d", i), d_idx, 5);
            check_val($sformatf("mm_mm_s0_%0d", i), m_idx, 0);
            check_val($sformatf("mm_mm_wrap%0d", i), m_wrap, 0);
        end
        a_in = 2'd1;
        step();
        check_val("mm_def_s6", d_idx, 6);
        check_val("mm_mm_stay_s0", m_idx, 0);
        check_val("mm_mm_wc", m_wc, 1);
        a_valid = 1'b0;

        // Gray and binary 12-state walk.
        b_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            b_in = 2'(i % 4);
            step();
            check_val($sformatf("gray_state%0d", i), g_state, gray_code[(i + 1) % 12]);
            check_val($sformatf("gray_idx%0d", i), g_idx, (i + 1) % 12);
            check_val($sformatf("gray_out%0d", i), g_out, gray_par[(i + 1) % 12]);
            check_val($sformatf("gray_wrap%0d", i), g_wrap, (i == 11) ? 1 : 0);
            check_val($sformatf("bin_state%0d", i), n_state, (i + 1) % 12);
        end
        b_valid = 1'b0;
        step();
        check_val("gray_wrap_end", g_wrap, 0);
        check_val("gray_wc", g_wc, 1);

        // Idle timeout from S3, then an advance on the last idle cycle.
        b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_in = 2'(i);
            step();
        end
        check_val("to_s3", g_idx, 3);
        b_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("to_hold%0d", i), g_idx, 3);
            check_val($sformatf("to_tev_lo%0d", i), g_tev, 0);
        end
        step();
        check_val("to_s0", g_idx, 0);
        check_val("to_state0", g_state, 0);
        check_val("to_tev", g_tev, 1);
        check_val("to_not_wrap", g_wrap, 0);
        step();
        check_val("to_tev_once", g_tev, 0);
        check_val("to_stay_s0", g_idx, 0);

        b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_in = 2'(i);
            step();
        end
        b_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("to2_hold%0d", i), g_idx, 3);
        end
        b_valid = 1'b1;
        b_in = 2'd3;
        step();
        check_val("to2_s4", g_idx, 4);
        check_val("to2_no_tev", g_tev, 0);
        b_valid = 1'b0;
        step();
        check_val("to2_no_tev_after", g_tev, 0);
        check_val("to2_hold_s4", g_idx, 4);

        // Illegal encodings and single-edge recovery.
        force u_def.r_state = 32'h6;
        #1 release u_def.r_state;
        #1;
        check_val("ill_oh_idx_reads0", d_idx, 0);
        check_val("ill_oh_flag_pre", d_ill, 0);
        step();
        check_val("ill_oh_state", d_state, 32'h1);
        check_val("ill_oh_flag", d_ill, 1);
        check_val("ill_oh_no_wrap", d_wrap, 0);
        repeat (2) step();
        check_val("ill_oh_sticky", d_ill, 1);
        force u_def.r_state = 32'h0;
        #1 release u_def.r_state;
        #1;
        check_val("ill_zero_out", d_out, 0);
        check_val("ill_zero_idx", d_idx, 0);
        step();
        check_val("ill_zero_state", d_state, 32'h1);
        check_val("ill_zero_flag", d_ill, 1);
        force u_bin.r_state = 4'd14;
        #1 release u_bin.r_state;
        #1;
        check_val("ill_bin_idx_reads0", n_idx, 0);
        step();
        check_val("ill_bin_state", n_state, 0);
        check_val("ill_bin_flag", n_ill, 1);

        // Asynchronous reset mid-sequence at S17 with three wraps.
        a_valid = 1'b1;
        for (int i = 0; i < 81; i++) begin
            a_in = 2'(i % 4);
            step();
        end
        check_val("ar_s17", d_idx, 17);
        check_val("ar_wc3", d_wc, 3);
        check_val("ar_ill_pre", d_ill, 1);
        a_in = 2'd1;
        #3 reset = 1'b1;
        #1;
        check_val("ar_state", d_state, 32'h1);
        check_val("ar_idx", d_idx, 0);
        check_val("ar_wc", d_wc, 0);
        check_val("ar_ill", d_ill, 0);
        check_val("ar_wrap", d_wrap, 0);
        check_val("ar_bin_ill", n_ill, 0);
        step();
        #2 reset = 1'b0;
        a_in = 2'd0;
        step();
        check_val("ar_resume_s1", d_idx, 1);
        a_in = 2'd1;
        step();
        check_val("ar_resume_s2", d_idx, 2);
        a_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_tracker_fsm.md
Name: seq_tracker_fsm

Overview:
Parametrised sequence-tracking FSM. It advances through NUM_STATES states when the qualified input symbol matches the symbol expected in the current state. It offers selectable state encoding (one-hot, binary, gray), a mismatch-restart mode, an idle timeout, wrap counting and illegal-state detection with recovery. It sits in the final-project datapath where the fixed 32-state one-hot tracker was used, and is the next-generation drop-in for it.

Parameters:
NUM_STATES, 32, number of states S0..S(NUM_STATES-1); legal range 2..256.
SYM_W, 2, input symbol width; expected symbol in state k = k mod 2**SYM_W.
ENCODING, 0, 0 = one-hot (STATE_W = NUM_STATES), 1 = binary, 2 = gray (STATE_W = clog2(NUM_STATES)).
MISMATCH_MODE, 0, 0 = hold state on mismatch, 1 = return to S0 on mismatch.
TIMEOUT, 0, 0 = disabled; else the FSM returns to S0 after TIMEOUT consecutive cycles without an advance while outside S0 (legal range 0..65535).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  qualifies `in`; the FSM only evaluates `in` when high
in  in  SYM_W  input symbol
state  out  STATE_W  encoded current-state register
state_idx  out  clog2(NUM_STATES)  decoded index of the current state
out_signal  out  1  XOR reduction of `state`
wrap  out  1  one-cycle pulse: the last state advanced to S0
wrap_count  out  16  number of wraps since reset, rolls over modulo 2**16
illegal  out  1  sticky flag: an illegal encoding was detected
timeout_evt  out  1  one-cycle pulse: a timeout return to S0 occurred

Behaviour:
- Reset (async assert, sync deassert at the clock edge): state = encoding of S0 (one-hot 1, binary/gray 0), state_idx = 0, wrap = 0, wrap_count = 0, illegal = 0, timeout_evt = 0, idle counter = 0. out_signal follows `state` (1 for one-hot, 0 otherwise).
- All outputs except out_signal and state_idx are registered. out_signal and state_idx are combinational from the state register.
- Latency: a symbol accepted at edge N is reflected in `state` after edge N.
- Match condition: in_valid && in == (idx mod 2**SYM_W).
- Next-state priority, highest first:
  1. Illegal recovery: go to S0 and set `illegal`.
  2. Advance: idx+1, or S0 when idx = NUM_STATES-1.
  3. Mismatch restart: applies when MISMATCH_MODE=1 && in_valid && no match; go to S0.
  4. Timeout: go to S0.
  5. Hold.
- Illegal encoding:
  - One-hot: state is not exactly one bit set (zero or multiple).
  - Binary/gray: decoded idx >= NUM_STATES.
  - While the state is illegal, state_idx reads 0.
  - Recovery to S0 takes exactly one edge.
  - `illegal` stays high until reset.
- Gray encoding: state = idx ^ (idx >> 1). Decode is the inverse prefix-XOR.
- wrap: high for the one cycle after the edge on which S(NUM_STATES-1) advanced to S0; wrap_count increments on that same edge. A mismatch, timeout or illegal return to S0 is not a wrap.
- Idle counter (only when TIMEOUT != 0):
  - Clears on any advance and on any entry to S0; held at 0 while in S0.
  - Otherwise increments each cycle.
  - When it equals TIMEOUT-1 and no advance occurs this cycle, the next state is S0, the counter clears, and timeout_evt pulses for one cycle.
- Simultaneous events: an advance beats a timeout in the same cycle (counter clears, no timeout_evt). An illegal state beats everything.
- in_valid low: no advance, no mismatch. The idle counter still runs.
- Reset mid-sequence: returns to S0 immediately (asynchronously). Sticky and count registers clear.
- No `unique case` fall-through: the decode default branch goes to S0.

Test Plan:
- Defaults: reset, then feed in = 00,01,10,11 repeated with in_valid = 1 for 32 cycles -> state_idx steps 0..31 then 0; wrap pulses once on the cycle after the 32nd symbol; wrap_count = 1; out_signal = 1 throughout.
- Defaults: in S5 (expects 01), apply in = 11 for 3 cycles, then 01 -> S5 held for 3 cycles, then S6. With MISMATCH_MODE=1 the same stimulus -> S0 after the first mismatch and no wrap.
- ENCODING=2, NUM_STATES=12: step through all states -> state = 0,1,3,2,6,7,5,4,12,13,15,14 and state_idx matches; wrap after S11; out_signal = parity of each code.
- TIMEOUT=4: reach S3, then drop in_valid -> S0 after exactly 4 idle cycles; timeout_evt pulses once. Repeat with a matching symbol on the 4th idle cycle -> advances to S4, no timeout_evt.
- Force the one-hot state register to 32'h00000006 (and separately to 0) -> S0 on the next edge; illegal = 1 and held until reset. Binary NUM_STATES=12 with forced 4'd14 -> same recovery.
- Assert reset asynchronously mid-sequence at S17 with wrap_count = 3 -> state = S0 and all counters/flags = 0 before the next clock edge; normal stepping resumes after deassertion.
